// File: rtl/axil_ram_loader.sv
// axil_ram_loader: AXI4-Lite write-only master that packs an incoming byte
// stream little-endian into DATA_WIDTH words and writes them one at a time.
//
// Handshake rule used on every channel here: a transfer happens on a rising
// clk edge where valid && ready are both high. A valid, once raised, is held
// with its payload stable until that edge. No ready or valid output depends
// combinationally on any input.
module axil_ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [2:0]            dbg_state
);

  localparam int LANE_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LANE_W-1:0]     lane;

  // Handshake-completion terms for the write phase: a channel counts as
  // finished if it already completed earlier or completes on this edge.
  logic aw_fin, w_fin;
  assign aw_fin = !m_axil_awvalid || m_axil_awready;
  assign w_fin  = !m_axil_wvalid  || m_axil_wready;

  // Status and ready outputs are pure state decodes, so they follow the
  // asynchronous reset immediately and never depend on inputs.
  assign s_tready      = (state == S_COLLECT);
  assign m_axil_bready = (state == S_RESP);
  assign busy          = (state == S_COLLECT) || (state == S_WRITE) || (state == S_RESP);
  assign done          = (state == S_DONE);
  assign m_axil_awaddr = addr_q;
  assign m_axil_awprot = 3'b000;
  assign dbg_state     = state;

  // Main load sequencer: collects bytes into a word, writes it, waits for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      remaining      <= '0;
      lane           <= '0;
      error          <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q       <= base_addr & ALIGN_MASK;
            remaining    <= length;
            error        <= 1'b0;
            lane         <= '0;
            m_axil_wdata <= '0;
            m_axil_wstrb <= '0;
            state        <= (length == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (s_tvalid) begin
            m_axil_wdata[8*lane +: 8] <= s_tdata;
            m_axil_wstrb[lane]        <= 1'b1;
            remaining                 <= remaining - 1'b1;
            lane                      <= lane + 1'b1;
            // Word is full or the stream is exhausted: launch the write.
            if ((lane == LAST_LANE) || (remaining == LEN_WIDTH'(1))) begin
              state          <= S_WRITE;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
          if (aw_fin && w_fin) state <= S_RESP;
        end
        S_RESP: begin
          if (m_axil_bvalid) begin
            if (m_axil_bresp != 2'b00) error <= 1'b1;
            addr_q <= addr_q + ADDR_STEP;
            if (remaining != '0) begin
              state        <= S_COLLECT;
              lane         <= '0;
              m_axil_wdata <= '0;
              m_axil_wstrb <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ram_loader.sv
// Directed bench for axil_ram_loader: byte feeder, AXI-Lite slave model with
// programmable ready delays and error injection, and a write monitor.
module tb_axil_ram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy, done, error;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [2:0]  dbg_state;

  axil_ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration and monitor state.
  int aw_delay = 0;
  int w_delay  = 0;
  int err_word = -1;
  int aw_tot = 0, w_tot = 0, b_tot = 0;
  int done_cnt = 0, busy_cnt = 0;
  logic [15:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [3:0]  s_q[$];
  logic [7:0]  src_q[$];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: record every completed handshake at the rising edge.
  always @(posedge clk) begin
    if (awvalid && awready) begin aw_q.push_back(awaddr); aw_tot <= aw_tot + 1; end
    if (wvalid && wready) begin w_q.push_back(wdata); s_q.push_back(wstrb); w_tot <= w_tot + 1; end
    if (bvalid && bready) b_tot <= b_tot + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Slave driver: readies after the programmed wait, B once both AW and W seen.
  initial begin
    int aw_wait, w_wait;
    aw_wait = 0; w_wait = 0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      bvalid = (aw_tot > b_tot) && (w_tot > b_tot);
      bresp  = (b_tot == err_word) ? 2'b10 : 2'b00;
    end
  end

  // Byte feeder: presents src_q head, pops it on an accepted handshake.
  initial begin
    s_tvalid = 1'b0; s_tdata = 8'h00;
    forever begin
      @(negedge clk);
      if (src_q.size() > 0) begin s_tdata = src_q[0]; s_tvalid = 1'b1; end
      else s_tvalid = 1'b0;
      @(posedge clk);
      if (s_tvalid && s_tready && src_q.size() > 0) void'(src_q.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + 8'(i));
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 500) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done_cnt != prev), 32'd1);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    if (idx < aw_q.size() && idx < w_q.size()) begin
      chk({tag, "_addr"}, 32'(aw_q[idx]), 32'(a));
      chk({tag, "_data"}, w_q[idx], d);
      chk({tag, "_strb"}, 32'(s_q[idx]), 32'(s));
    end else begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  // Directed test sequence
  initial begin
    int base_i, d0, b0, n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({busy, done, error, s_tready, awvalid, wvalid, bready}), 32'd0);
    chk("rst_awaddr", 32'(awaddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_awprot", 32'(awprot), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two full words
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h01, 8);
    do_start(16'h0100, 16'd8);
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("t1_nwr", 32'(aw_q.size() - base_i), 32'd2);
    chk_write("t1_w0", base_i, 16'h0100, 32'h04030201, 4'hF);
    chk_write("t1_w1", base_i + 1, 16'h0104, 32'h08070605, 4'hF);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_error", 32'(error), 32'd0);

    // Unaligned base, partial last word
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h11, 5);
    do_start(16'h0203, 16'd5);
    wait_done(d0);
    chk_write("t2_w0", base_i, 16'h0200, 32'h14131211, 4'hF);
    chk_write("t2_w1", base_i + 1, 16'h0204, 32'h00000015, 4'b0001);

    // Zero length: done the cycle after start is taken, no bus activity
    base_i = aw_q.size(); d0 = done_cnt; b0 = busy_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 16'h1234; length = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t3_done_hi", 32'(done), 32'd1);
    chk("t3_busy_lo", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_done_lo", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("t3_nwr", 32'(aw_q.size() - base_i), 32'd0);
    chk("t3_busy_never", 32'(busy_cnt - b0), 32'd0);
    chk("t3_pulses", 32'(done_cnt - d0), 32'd1);

    // AW delayed, W immediate
    aw_delay = 3; w_delay = 0;
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h21, 4);
    do_start(16'h0300, 16'd4);
    n = 0;
    while (!wvalid && n < 100) begin @(negedge clk); n++; end
    chk("t4_wvalid_up", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clk);
    chk("t4_after_w", 32'({awvalid, wvalid}), 32'b10);
    wait_done(d0);
    chk("t4_naw", 32'(aw_q.size() - base_i), 32'd1);
    chk("t4_nw", 32'(w_q.size() - base_i), 32'd1);
    chk_write("t4_w0", base_i, 16'h0300, 32'h24232221, 4'hF);

    // W delayed, AW immediate
    aw_delay = 0; w_delay = 3;
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h31, 4);
    do_start(16'h0400, 16'd4);
    n = 0;
    while (!awvalid && n < 100) begin @(negedge clk); n++; end
    chk("t5_awvalid_up", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clk);
    chk("t5_after_aw", 32'({awvalid, wvalid}), 32'b01);
    wait_done(d0);
    chk("t5_naw", 32'(aw_q.size() - base_i), 32'd1);
    chk("t5_nw", 32'(w_q.size() - base_i), 32'd1);
    chk_write("t5_w0", base_i, 16'h0400, 32'h34333231, 4'hF);
    w_delay = 0;

    // Error response on first of three words; load continues
    base_i = aw_q.size(); d0 = done_cnt;
    err_word = b_tot;
    push_bytes(8'h41, 12);
    do_start(16'h0500, 16'd12);
    wait_done(d0);
    chk("t6_nwr", 32'(aw_q.size() - base_i), 32'd3);
    chk_write("t6_w2", base_i + 2, 16'h0508, 32'h4C4B4A49, 4'hF);
    chk("t6_error_set", 32'(error), 32'd1);
    err_word = -1;
    d0 = done_cnt;
    do_start(16'h0000, 16'd0);
    wait_done(d0);
    chk("t6_error_clr", 32'(error), 32'd0);

    // Address wrap at top of space
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h51, 8);
    do_start(16'hFFFC, 16'd8);
    wait_done(d0);
    chk_write("t7_w0", base_i, 16'hFFFC, 32'h54535251, 4'hF);
    chk_write("t7_w1", base_i + 1, 16'h0000, 32'h58575655, 4'hF);

    // Reset in the middle of collecting a word
    base_i = aw_q.size(); d0 = done_cnt;
    push_bytes(8'h61, 2);
    do_start(16'h0600, 16'd8);
    repeat (4) @(negedge clk);
    chk("t8_collecting", 32'({busy, s_tready}), 32'b11);
    src_q.delete();
    rst_n = 1'b0;
    #1;
    chk("t8_rst_ctrl", 32'({busy, done, error, s_tready, awvalid, wvalid, bready}), 32'd0);
    chk("t8_rst_wdata", wdata, 32'd0);
    chk("t8_rst_wstrb", 32'(wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t8_idle", 32'({busy, s_tready}), 32'b00);
    chk("t8_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t8_no_write", 32'(aw_q.size() - base_i), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
